alu_share_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational ALU between NREQ requesters (one per core in the multi-core build, or board-level test drivers).
- Latches the winning requester's operands and opcode, drives the ALU for one cycle, and registers the result and flags.
- Returns the result with a one-cycle ack pulse to the winning requester.
- Sits between the requesters and a single alu instance, driving its port_a, port_b and ALUOP and sampling port_out, negative, overflow and zero.

---
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 tb/tb_alu_share_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// Define ALU_ARB_STATS_EN to build saturating 16-bit per-requester grant counters on grant_cnt.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int WORD_W = 32,
  parameter int OP_W = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0] req_op,
  output logic [NREQ-1:0]      ack,
  output logic [WORD_W-1:0]    rdata,
  output logic [2:0]           rflags,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic [WORD_W-1:0]    alu_port_a,
  output logic [WORD_W-1:0]    alu_port_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [WORD_W-1:0]    alu_port_out,
  input  logic                 alu_neg,
  input  logic                 alu_ovf,
  input  logic                 alu_zero,
  output logic [NREQ*16-1:0]   grant_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_gid, w_win;
  logic [NREQ-1:0] w_cand, r_ack;
  logic [WORD_W-1:0] r_a, r_b, r_rdata;
  logic [OP_W-1:0] r_op;
  logic [2:0] r_flags;
  logic w_found, w_grant;
  // The requester just acked still holds req during DONE, so it is masked out.
  always_comb begin
    w_cand = req & ((r_state == S_DONE) ? ~(NREQ'(1) << r_gid) : '1);
    w_found = 1'b0;
    w_win = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_cand[IW'((int'(r_ptr) + k) % NREQ)]) begin
        w_found = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end
  always_comb begin
    w_next = (r_state == S_BUSY) ? S_DONE : (w_found ? S_BUSY : S_IDLE);
    w_grant = (r_state != S_BUSY) && w_found;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_gid <= '0;
      r_ptr <= '0;
      r_ack <= '0;
      r_rdata <= '0;
      r_flags <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_a <= req_a[w_win*WORD_W +: WORD_W];
        r_b <= req_b[w_win*WORD_W +: WORD_W];
        r_op <= req_op[w_win*OP_W +: OP_W];
        r_gid <= w_win;
      end
      if (r_state == S_BUSY) begin
        r_rdata <= alu_port_out;
        r_flags <= {alu_neg, alu_ovf, alu_zero};
        r_ack <= NREQ'(1) << r_gid;
        r_ptr <= (r_gid == IW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
      end
    end
  end
  assign ack = r_ack;
  assign rdata = r_rdata;
  assign rflags = r_flags;
  assign grant_id = r_gid;
  assign busy = (r_state == S_BUSY);
  assign alu_port_a = r_a;
  assign alu_port_b = r_b;
  assign alu_op = r_op;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt [NREQ];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else if (r_state == S_BUSY && r_cnt[r_gid] != 16'hFFFF) begin
      r_cnt[r_gid] <= r_cnt[r_gid] + 16'd1;
    end
  end
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = r_cnt[g];
  end
`else
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req;
  logic [63:0] req_a, req_b;
  logic [7:0] req_op;
  logic [1:0] ack;
  logic [31:0] rdata, alu_port_a, alu_port_b, alu_port_out;
  logic [2:0] rflags;
  logic [0:0] grant_id;
  logic busy, alu_neg, alu_ovf, alu_zero;
  logic [3:0] alu_op;
  logic [31:0] grant_cnt;
  typedef struct packed {logic [0:0] id; logic [31:0] d; logic [2:0] f;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_err = 0;
  int n;
  bit to;

  alu_share_arbiter dut (
    .CLK(clk), .RST(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .ack(ack), .rdata(rdata), .rflags(rflags), .grant_id(grant_id), .busy(busy),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .alu_op(alu_op),
    .alu_port_out(alu_port_out), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Returns {neg, ovf, zero, result}; op 0 = ADD, 1 = SUB, anything else = AND.
  function automatic logic [34:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic v;
    r = (op == 4'd0) ? a + b : (op == 4'd1) ? a - b : a & b;
    v = (op == 4'd0) ? (a[31] == b[31]) && (r[31] != a[31]) :
        (op == 4'd1) ? (a[31] != b[31]) && (r[31] != a[31]) : 1'b0;
    return {r[31], v, r == 32'd0, r};
  endfunction

  assign {alu_neg, alu_ovf, alu_zero, alu_port_out} = alu_f(alu_port_a, alu_port_b, alu_op);

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [34:0] m;
    m = alu_f(a, b, op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4] = op;
    req[i] = 1'b1;
    sb.push_back('{id: 1'(i), d: m[31:0], f: m[34:32]});
  endtask

  task automatic wait_ack(output int cyc, output bit tmo);
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < 20 && tmo; k++) begin
      @(negedge clk);
      cyc++;
      if (ack != 2'b00) tmo = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_chk++; if (rflags !== 3'b000) begin n_err++; $display("FAIL reset_rflags: got %b want 000", rflags); end
    n_chk++; if (grant_id !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_gid_busy: got %b/%b want 0/0", grant_id, busy); end
    n_chk++; if ({alu_port_a, alu_port_b, alu_op} !== 68'h0) begin n_err++; $display("FAIL reset_alu_regs: got %h %h %h want 0", alu_port_a, alu_port_b, alu_op); end
    n_chk++; if (grant_cnt !== 32'h0) begin n_err++; $display("FAIL reset_grant_cnt: got %h want 0", grant_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    set_req(0, 32'h5, 32'h3, 4'd0);
    @(negedge clk);
    n_chk++; if (busy !== 1'b1 || ack !== 2'b00) begin n_err++; $display("FAIL add_busy: got busy=%b ack=%b want 1/00", busy, ack); end
    n_chk++; if (alu_port_a !== 32'h5 || alu_port_b !== 32'h3 || alu_op !== 4'd0) begin n_err++; $display("FAIL add_alu_drive: got %h %h %h want 5 3 0", alu_port_a, alu_port_b, alu_op); end
    wait_ack(n, to);
    e = sb.pop_front();
    n_chk++; if (to || n != 1) begin n_err++; $display("FAIL add_latency: got %0d extra cycles (timeout %0b) want 1", n, to); end
    n_chk++; if (ack !== 2'b01 || grant_id !== 1'b0) begin n_err++; $display("FAIL add_ack: got %b gid %b want 01 gid 0", ack, grant_id); end
    n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL add_result: got %h/%b want %h/%b", rdata, rflags, e.d, e.f); end
    req = '0;
    @(negedge clk);
    n_chk++; if (ack !== 2'b00 || busy !== 1'b0 || rdata !== e.d) begin n_err++; $display("FAIL add_after: got ack=%b busy=%b rdata=%h want 00/0/%h", ack, busy, rdata, e.d); end
  endtask

  task automatic test_flags();
    set_req(1, 32'h7FFF_FFFF, 32'h1, 4'd0);
    wait_ack(n, to);
    e = sb.pop_front();
    n_chk++; if (to || n != 2) begin n_err++; $display("FAIL ovf_latency: got %0d (timeout %0b) want 2", n, to); end
    n_chk++; if (ack !== 2'b10 || grant_id !== 1'b1) begin n_err++; $display("FAIL ovf_ack: got %b gid %b want 10 gid 1", ack, grant_id); end
    n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL ovf_result: got %h/%b want %h/%b", rdata, rflags, e.d, e.f); end
    req = '0;
    @(negedge clk);
    set_req(1, 32'h1234, 32'h1234, 4'd1);
    wait_ack(n, to);
    e = sb.pop_front();
    n_chk++; if (to || ack !== 2'b10) begin n_err++; $display("FAIL sub_ack: got %b (timeout %0b) want 10", ack, to); end
    n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL sub_result: got %h/%b want %h/%b", rdata, rflags, e.d, e.f); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int left[2];
    left = '{2, 2};
    set_req(0, 32'h100, 32'h11, 4'd0);
    set_req(1, 32'h900, 32'h22, 4'd1);
    for (int k = 0; k < 6; k++) begin
      wait_ack(n, to);
      e = sb.pop_front();
      n_chk++; if (to || n != 2) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d (timeout %0b) want 2", k, n, to); end
      n_chk++; if (ack !== (2'b01 << (k % 2)) || grant_id !== e.id) begin n_err++; $display("FAIL b2b_order[%0d]: got ack=%b gid=%b want gid %b", k, ack, grant_id, e.id); end
      n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", k, rdata, rflags, e.d, e.f); end
      if (left[k % 2] > 0) begin
        left[k % 2]--;
        set_req(k % 2, 32'h100 * (k + 3), 32'h7 + k, 4'(k % 2));
      end else req[k % 2] = 1'b0;
    end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || ack !== 2'b00) begin n_err++; $display("FAIL b2b_idle: got busy=%b ack=%b want 0/00", busy, ack); end
  endtask

  task automatic test_drop_in_busy();
    set_req(1, 32'h50, 32'h20, 4'd1);
    @(negedge clk);
    req[1] = 1'b0;
    req_a[63:32] = 32'hFFFF_FFFF;
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy: got %b want 1", busy); end
    wait_ack(n, to);
    e = sb.pop_front();
    n_chk++; if (to || n != 1 || ack !== 2'b10) begin n_err++; $display("FAIL drop_ack: got %b after %0d (timeout %0b) want 10 after 1", ack, n, to); end
    n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL drop_result: got %h/%b want %h/%b", rdata, rflags, e.d, e.f); end
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || ack !== 2'b00) begin n_err++; $display("FAIL drop_idle: got busy=%b ack=%b want 0/00", busy, ack); end
  endtask

  task automatic test_rst_in_busy();
    set_req(0, 32'h2, 32'h2, 4'd0);
    wait_ack(n, to);
    e = sb.pop_front();
    n_chk++; if (to || rdata !== e.d) begin n_err++; $display("FAIL rst_pre: got %h (timeout %0b) want %h", rdata, to, e.d); end
    req = '0;
    @(negedge clk);
    set_req(1, 32'h9, 32'h9, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (ack !== 2'b00 || busy !== 1'b0 || rdata !== 32'h0 || rflags !== 3'b000 || grant_id !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs: got ack=%b busy=%b rdata=%h rflags=%b gid=%b want all 0", ack, busy, rdata, rflags, grant_id);
    end
    @(negedge clk);
    n_chk++; if (ack !== 2'b00) begin n_err++; $display("FAIL rst_no_ack: got %b want 00", ack); end
    sb.delete();
    set_req(0, 32'h10, 32'h1, 4'd0);
    set_req(1, 32'h9, 32'h9, 4'd1);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_ack(n, to);
      e = sb.pop_front();
      n_chk++; if (to || ack !== (2'b01 << k) || grant_id !== e.id) begin n_err++; $display("FAIL rst_order[%0d]: got ack=%b gid=%b (timeout %0b) want gid %b", k, ack, grant_id, to, e.id); end
      n_chk++; if (rdata !== e.d || rflags !== e.f) begin n_err++; $display("FAIL rst_result[%0d]: got %h/%b want %h/%b", k, rdata, rflags, e.d, e.f); end
      req[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_stats();
    logic [15:0] x0, x1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_req(i < 5 ? 0 : 1, 32'(i), 32'h1, 4'd2);
      wait_ack(n, to);
      e = sb.pop_front();
      n_chk++; if (to || rdata !== e.d || grant_id !== e.id) begin n_err++; $display("FAIL stats_op[%0d]: got %h gid %b (timeout %0b) want %h gid %b", i, rdata, grant_id, to, e.d, e.id); end
      req = '0;
      @(negedge clk);
    end
`ifdef ALU_ARB_STATS_EN
    x0 = 16'd5; x1 = 16'd3;
`else
    x0 = 16'd0; x1 = 16'd0;
`endif
    n_chk++; if (grant_cnt[15:0] !== x0) begin n_err++; $display("FAIL stats_cnt0: got %0d want %0d", grant_cnt[15:0], x0); end
    n_chk++; if (grant_cnt[31:16] !== x1) begin n_err++; $display("FAIL stats_cnt1: got %0d want %0d", grant_cnt[31:16], x1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_back_to_back();
    test_drop_in_busy();
    test_rst_in_busy();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
